// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - board/datapath signal bundle for the run/step/halt sequencer
interface cpu_run_ctrl_if;
    logic        run_sw;
    logic        step_btn;
    logic        halt_req;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_en;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] instr_count;

    // Board inputs and datapath status side
    modport master (
        output run_sw, step_btn, halt_req, pc, bp_en, bp_addr,
        input  cpu_en, state, halt_cause, instr_count
    );

    // Sequencer side
    modport slave (
        input  run_sw, step_btn, halt_req, pc, bp_en, bp_addr,
        output cpu_en, state, halt_cause, instr_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt sequencer generating cpu_en (CPU_RUN_CTRL_LIMIT_EN adds instruction limit)
module cpu_run_ctrl #(
    parameter int          DEB_CYCLES = 200000,
    parameter logic [31:0] MAX_INSTR  = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    logic             run_meta_q, run_meta_d;
    logic             run_s_q, run_s_d;
    logic             step_meta_q, step_meta_d;
    logic             step_s_q, step_s_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_db_q, step_db_d;
    logic             step_db_prev_q, step_db_prev_d;
    state_t           state_q, state_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic [31:0]      instr_count_q, instr_count_d;

    logic             step_pulse;
    logic             bp_hit;
    logic             cpu_en;

`ifdef CPU_RUN_CTRL_LIMIT_EN
    localparam logic [31:0] INSTR_LAST = MAX_INSTR - 32'd1;
`else
    logic [31:0] limit_unused;
    assign limit_unused = MAX_INSTR;
`endif

    assign step_pulse = step_db_q & ~step_db_prev_q;
    assign bp_hit     = bus.bp_en && (bus.pc == bus.bp_addr);

    // Synchronisers and step debouncer: a new level is accepted only after
    // DEB_CYCLES consecutive samples that differ from the accepted level.
    always_comb begin
        run_meta_d     = bus.run_sw;
        run_s_d        = run_meta_q;
        step_meta_d    = bus.step_btn;
        step_s_d       = step_meta_q;
        deb_cnt_d      = deb_cnt_q;
        step_db_d      = step_db_q;
        step_db_prev_d = step_db_q;
        if (step_s_q == step_db_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            step_db_d = step_s_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Sequencer next state, halt cause, commit enable and commit counter.
    // A halting or breakpointed instruction in RUN is never committed.
    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        cpu_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_s_q) begin
                    state_d = S_RUN;
                end else if (step_pulse) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                cpu_en = !bus.halt_req && !bp_hit;
                if (bus.halt_req) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b01;
                end else if (bp_hit) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b10;
`ifdef CPU_RUN_CTRL_LIMIT_EN
                end else if (instr_count_q == INSTR_LAST) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b11;
`endif
                end else if (!run_s_q) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                cpu_en = !bus.halt_req;
                if (bus.halt_req) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b01;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (!run_s_q) begin
                    state_d      = S_IDLE;
                    halt_cause_d = 2'b00;
                end
            end
        endcase
        instr_count_d = instr_count_q + {31'd0, cpu_en};
    end

    // State registers with asynchronous reset so cpu_en drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_meta_q     <= 1'b0;
            run_s_q        <= 1'b0;
            step_meta_q    <= 1'b0;
            step_s_q       <= 1'b0;
            deb_cnt_q      <= '0;
            step_db_q      <= 1'b0;
            step_db_prev_q <= 1'b0;
            state_q        <= S_IDLE;
            halt_cause_q   <= 2'b00;
            instr_count_q  <= 32'd0;
        end else begin
            run_meta_q     <= run_meta_d;
            run_s_q        <= run_s_d;
            step_meta_q    <= step_meta_d;
            step_s_q       <= step_s_d;
            deb_cnt_q      <= deb_cnt_d;
            step_db_q      <= step_db_d;
            step_db_prev_q <= step_db_prev_d;
            state_q        <= state_d;
            halt_cause_q   <= halt_cause_d;
            instr_count_q  <= instr_count_d;
        end
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.state       = state_q;
    assign bus.halt_cause  = halt_cause_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed vector bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(
        .DEB_CYCLES(4),
        .MAX_INSTR (32'd10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        run_sw;
        logic        halt_req;
        logic [31:0] pc;
        logic        bp_en;
        logic [31:0] bp_addr;
        logic        exp_en;
        logic [1:0]  exp_state;
        logic [1:0]  exp_cause;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[26];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic r, input logic h, input logic [31:0] p,
                                input logic be, input logic [31:0] ba, input logic en,
                                input logic [1:0] st, input logic [1:0] cs,
                                input logic [31:0] cnt);
        vec_t v;
        v.run_sw = r; v.halt_req = h; v.pc = p; v.bp_en = be; v.bp_addr = ba;
        v.exp_en = en; v.exp_state = st; v.exp_cause = cs; v.exp_count = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [1:0] st,
                           input logic [1:0] cs, input logic [31:0] cnt);
        chk({tag, " cpu_en"}, {31'd0, bus.cpu_en}, {31'd0, en});
        chk({tag, " state"}, {30'd0, bus.state}, {30'd0, st});
        chk({tag, " halt_cause"}, {30'd0, bus.halt_cause}, {30'd0, cs});
        chk({tag, " instr_count"}, bus.instr_count, cnt);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.run_sw   = vecs[i].run_sw;
            bus.halt_req = vecs[i].halt_req;
            bus.pc       = vecs[i].pc;
            bus.bp_en    = vecs[i].bp_en;
            bus.bp_addr  = vecs[i].bp_addr;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_state,
                    vecs[i].exp_cause, vecs[i].exp_count);
            next_cycle();
        end
    endtask

    initial begin
        // Reset release with run_sw held, run to breakpoint at 0x10, halt, back to IDLE
        vecs[0]  = mk(1, 0, 32'h00, 1, 32'h10, 0, 2'b00, 2'b00, 0);
        vecs[1]  = mk(1, 0, 32'h00, 1, 32'h10, 0, 2'b00, 2'b00, 0);
        vecs[2]  = mk(1, 0, 32'h00, 1, 32'h10, 0, 2'b00, 2'b00, 0);
        vecs[3]  = mk(1, 0, 32'h00, 1, 32'h10, 1, 2'b01, 2'b00, 0);
        vecs[4]  = mk(1, 0, 32'h04, 1, 32'h10, 1, 2'b01, 2'b00, 1);
        vecs[5]  = mk(1, 0, 32'h08, 1, 32'h10, 1, 2'b01, 2'b00, 2);
        vecs[6]  = mk(1, 0, 32'h0C, 1, 32'h10, 1, 2'b01, 2'b00, 3);
        vecs[7]  = mk(1, 0, 32'h10, 1, 32'h10, 0, 2'b01, 2'b00, 4);
        vecs[8]  = mk(1, 0, 32'h10, 1, 32'h10, 0, 2'b11, 2'b10, 4);
        vecs[9]  = mk(0, 0, 32'h10, 1, 32'h10, 0, 2'b11, 2'b10, 4);
        vecs[10] = mk(0, 0, 32'h10, 1, 32'h10, 0, 2'b11, 2'b10, 4);
        vecs[11] = mk(0, 0, 32'h10, 1, 32'h10, 0, 2'b11, 2'b10, 4);
        vecs[12] = mk(0, 0, 32'h10, 1, 32'h10, 0, 2'b00, 2'b00, 4);
        // Run again, halt_req and breakpoint together, then leave HALT
        vecs[13] = mk(1, 0, 32'h14, 1, 32'h20, 0, 2'b00, 2'b00, 5);
        vecs[14] = mk(1, 0, 32'h14, 1, 32'h20, 0, 2'b00, 2'b00, 5);
        vecs[15] = mk(1, 0, 32'h14, 1, 32'h20, 0, 2'b00, 2'b00, 5);
        vecs[16] = mk(1, 0, 32'h14, 1, 32'h20, 1, 2'b01, 2'b00, 5);
        vecs[17] = mk(1, 0, 32'h18, 1, 32'h20, 1, 2'b01, 2'b00, 6);
        vecs[18] = mk(1, 1, 32'h20, 1, 32'h20, 0, 2'b01, 2'b00, 7);
        vecs[19] = mk(1, 1, 32'h20, 1, 32'h20, 0, 2'b11, 2'b01, 7);
        vecs[20] = mk(1, 0, 32'h20, 1, 32'h20, 0, 2'b11, 2'b01, 7);
        vecs[21] = mk(1, 0, 32'h20, 1, 32'h20, 0, 2'b11, 2'b01, 7);
        vecs[22] = mk(0, 0, 32'h20, 1, 32'h20, 0, 2'b11, 2'b01, 7);
        vecs[23] = mk(0, 0, 32'h20, 1, 32'h20, 0, 2'b11, 2'b01, 7);
        vecs[24] = mk(0, 0, 32'h20, 1, 32'h20, 0, 2'b11, 2'b01, 7);
        vecs[25] = mk(0, 0, 32'h20, 1, 32'h20, 0, 2'b00, 2'b00, 7);

        bus.run_sw   = 1'b1;
        bus.step_btn = 1'b0;
        bus.halt_req = 1'b0;
        bus.pc       = 32'h0;
        bus.bp_en    = 1'b1;
        bus.bp_addr  = 32'h10;
        rst          = 1'b1;
        repeat (3) next_cycle();
        chk_all("reset", 1'b0, 2'b00, 2'b00, 32'd0);
        rst = 1'b0;

        apply_rows(0, 12);

        // Bouncy press 1-0-1 then held: STEP exactly 9 edges after first touch,
        // breakpoint at pc 0x10 is passed by the single commit
        for (int j = 0; j < 25; j++) begin
            bus.step_btn = (j == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk_all($sformatf("step j%0d", j), (j == 9), (j == 9) ? 2'b10 : 2'b00,
                    2'b00, (j >= 10) ? 32'd5 : 32'd4);
            next_cycle();
        end
        bus.step_btn = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("release j%0d state", j), {30'd0, bus.state}, 32'd0);
            next_cycle();
        end

        apply_rows(13, 25);

        // Free run towards the instruction limit
        bus.run_sw = 1'b1;
        bus.bp_en  = 1'b0;
        bus.pc     = 32'h100;
        repeat (3) next_cycle();
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
`ifdef CPU_RUN_CTRL_LIMIT_EN
            chk_all($sformatf("limit j%0d", j), (j < 3), (j >= 3) ? 2'b11 : 2'b01,
                    (j >= 3) ? 2'b11 : 2'b00, (j >= 3) ? 32'd10 : 32'(7 + j));
`else
            chk_all($sformatf("nolimit j%0d", j), 1'b1, 2'b01, 2'b00, 32'(7 + j));
`endif
            next_cycle();
        end
`ifdef CPU_RUN_CTRL_LIMIT_EN
        bus.run_sw = 1'b0;
        repeat (3) next_cycle();
        bus.run_sw = 1'b1;
        repeat (3) next_cycle();
`endif

        // Asynchronous reset while committing
        chk("pre-reset cpu_en", {31'd0, bus.cpu_en}, 32'd1);
        rst        = 1'b1;
        bus.run_sw = 1'b0;
        #1;
        chk_all("async reset", 1'b0, 2'b00, 2'b00, 32'd0);
        repeat (3) next_cycle();
        rst = 1'b0;

        // Step pulse and run_s arrive in the same IDLE cycle: RUN wins
        for (int j = 0; j < 10; j++) begin
            bus.step_btn = 1'b1;
            if (j == 4) bus.run_sw = 1'b1;
            @(negedge clk);
            chk_all($sformatf("race j%0d", j), (j >= 7), (j >= 7) ? 2'b01 : 2'b00,
                    2'b00, (j >= 7) ? 32'(j - 7) : 32'd0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
